// File: rtl/imem_loader.sv
// Boot loader for the instruction RAM: turns a little-endian byte stream into sequential
// 32-bit RAM writes, then releases the core. Define IMEM_LOADER_CHECKSUM_EN to require an XOR trailer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_LEN     | collecting the 4 bytes of the word count N
// S_DATA    | assembling data words, one write strobe per completed word
// S_WR_LAST | one idle cycle so the final write settles before release
// S_CHK     | collecting the 4 checksum bytes (checksum build only)
// S_DONE    | image loaded, core released, held until rst
// S_ERR     | load aborted, core held in reset until rst
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wen_n,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS + 1);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WR_LAST,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_sr;
    logic [31:0]       word_full;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  len_q;
    logic              accept;
    logic              last_byte;
    logic              data_left;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       xor_q;
`endif

    // Bytes shift in from the top, so after four bytes the first one sits in [7:0].
    assign word_full = {in_data, word_sr[31:8]};
    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign data_left = (idx != len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_LEN: begin
                in_ready = 1'b1;
                if (last_byte) begin
                    if (word_full > DEPTH_LIM) begin
                        state_nxt = S_ERR;
                    end else if (word_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Once all N words are in, the final strobe cycle stops intake and moves on.
                in_ready = data_left;
                if (!data_left) begin
                    state_nxt = S_WR_LAST;
                end
            end
            S_WR_LAST: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nxt = S_CHK;
`else
                state_nxt = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (last_byte) begin
                    state_nxt = (word_full == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_DONE;
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    // Status flags are registered so the core reset never sees decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            err      <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERR);
            core_rst <= (state_nxt != S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            word_sr    <= 32'd0;
            idx        <= '0;
            len_q      <= '0;
            imem_wen_n <= 1'b1;
            imem_addr  <= BASE_ADDR;
            imem_din   <= 32'd0;
        end else begin
            imem_wen_n <= 1'b1;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_sr  <= word_full;
            end
            if ((state == S_LEN) && last_byte && (word_full <= DEPTH_LIM)) begin
                len_q <= word_full[IDX_W-1:0];
            end
            if ((state == S_DATA) && last_byte) begin
                imem_wen_n <= 1'b0;
                imem_addr  <= BASE_ADDR + (32'(idx) << 2);
                imem_din   <= word_full;
                idx        <= idx + IDX_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= 32'd0;
        end else if ((state == S_DATA) && last_byte) begin
            xor_q <= xor_q ^ word_full;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of load scenarios plus random images checked
// against a byte-stream reference model, and hand-written timing/reset/overflow sequences.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_wen_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        core_rst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_wen_n (imem_wen_n),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  stim[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        m_done;
    logic        m_err;
    int          dbl_strobe = 0;
    int          both_flags = 0;
    logic        prev_wen_low = 1'b0;

    typedef struct {
        logic [31:0] n;
        int          gap;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    always @(negedge clk) begin
        if (!rst && imem_wen_n === 1'b0) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_din);
            if (prev_wen_low) dbl_strobe++;
        end
        prev_wen_low = (imem_wen_n === 1'b0);
        if (done === 1'b1 && err === 1'b1) both_flags++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
    endtask

    // Generates N, the random payload and (checksum build) a trailer, optionally corrupted.
    task automatic build(input logic [31:0] n, input bit corrupt);
        logic [31:0] w;
        logic [31:0] x;
        stim.delete();
        push_word(n);
        x = 32'd0;
        if (n <= DEPTH) begin
            for (int k = 0; k < int'(n); k++) begin
                w = $urandom();
                push_word(w);
                x ^= w;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            push_word(corrupt ? ~x : x);
`endif
        end
    endtask

    task automatic send(input int gap);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < stim.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stim[i];
                if (in_ready) i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bytes_accepted", i, stim.size());
    endtask

    // Reference: interpret the byte stream directly as count, words and trailer.
    task automatic model_expect();
        logic [31:0] n;
        logic [31:0] w;
        logic [31:0] x;
        int          base;
        exp_addr.delete();
        exp_data.delete();
        n = {stim[3], stim[2], stim[1], stim[0]};
        if (n > DEPTH) begin
            m_done = 1'b0;
            m_err  = 1'b1;
            return;
        end
        x = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
            base = 4 + 4 * k;
            w = {stim[base+3], stim[base+2], stim[base+1], stim[base]};
            exp_addr.push_back(BASE + 32'(4 * k));
            exp_data.push_back(w);
            x ^= w;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        base = 4 + 4 * int'(n);
        w = {stim[base+3], stim[base+2], stim[base+1], stim[base]};
        m_done = (w == x);
        m_err  = (w != x);
`else
        m_done = 1'b1;
        m_err  = 1'b0;
`endif
    endtask

    task automatic compare_model(input string tag);
        int nw;
        model_expect();
        check({tag, "_nwrites"}, wr_addr_q.size(), exp_addr.size());
        nw = (wr_addr_q.size() < exp_addr.size()) ? wr_addr_q.size() : exp_addr.size();
        for (int k = 0; k < nw; k++) begin
            check({tag, "_addr"}, wr_addr_q[k], exp_addr[k]);
            check({tag, "_data"}, wr_data_q[k], exp_data[k]);
        end
        check({tag, "_done"}, done, m_done);
        check({tag, "_err"}, err, m_err);
        check({tag, "_core_rst"}, core_rst, !m_done);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic load_basic();
        stim.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(32'h0010_0080);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'd2,          0,  1'b1, 1'b0};
        vecs[1] = '{32'd0,          0,  1'b1, 1'b0};
        vecs[2] = '{32'd257,        0,  1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF,  0,  1'b0, 1'b1};
        vecs[4] = '{32'd256,        30, 1'b1, 1'b0};
        vecs[5] = '{32'd1,          50, 1'b1, 1'b0};
        vecs[6] = '{32'd5,          20, 1'b1, 1'b0};

        // Reset values while rst is held
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wen_n", imem_wen_n, 1'b1);
        check("rst_addr", imem_addr, BASE);
        check("rst_din", imem_din, 32'd0);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);

        // Basic load with exact strobe/release timing
        do_reset();
        load_basic();
        send(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("basic_strobe_wen", imem_wen_n, 1'b0);
        check("basic_strobe_addr", imem_addr, 32'h4);
        check("basic_strobe_din", imem_din, 32'h0010_0093);
        check("basic_strobe_done", done, 1'b0);
        @(negedge clk);
        check("basic_wrlast_done", done, 1'b0);
        check("basic_wrlast_ready", in_ready, 1'b0);
        @(negedge clk);
        check("basic_rel_done", done, 1'b1);
        check("basic_rel_core_rst", core_rst, 1'b0);
`else
        repeat (3) @(negedge clk);
        check("chk_good_done", done, 1'b1);
`endif
        check("basic_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("basic_w0_addr", wr_addr_q[0], 32'h0);
            check("basic_w0_data", wr_data_q[0], 32'h0000_0013);
            check("basic_w1_addr", wr_addr_q[1], 32'h4);
            check("basic_w1_data", wr_data_q[1], 32'h0010_0093);
        end
        repeat (2) @(negedge clk);
        check("basic_done_sticky", done, 1'b1);

        // Same image with random gaps
        do_reset();
        load_basic();
        send(50);
        repeat (3) @(negedge clk);
        compare_model("gaps");

        // Empty image
        do_reset();
        build(32'd0, 1'b0);
        send(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("empty_done", done, 1'b1);
        check("empty_core_rst", core_rst, 1'b0);
        check("empty_in_ready", in_ready, 1'b0);
`endif
        repeat (2) @(negedge clk);
        compare_model("empty");

        // Overflow with in_valid held high afterwards
        do_reset();
        build(32'd257, 1'b0);
        send(0);
        in_valid = 1'b1; in_data = 8'h55;
        for (int c = 0; c < 3; c++) begin
            check("ovf_in_ready", in_ready, 1'b0);
            check("ovf_err", err, 1'b1);
            check("ovf_core_rst", core_rst, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("ovf_nwrites", wr_addr_q.size(), 0);
        check("ovf_done", done, 1'b0);

        // Reset after 6 data bytes, then the full image
        do_reset();
        load_basic();
        while (stim.size() > 10) void'(stim.pop_back());
        send(0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_wen_n", imem_wen_n, 1'b1);
        check("midrst_addr", imem_addr, BASE);
        check("midrst_din", imem_din, 32'd0);
        check("midrst_core_rst", core_rst, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        do_reset();
        load_basic();
        send(0);
        repeat (3) @(negedge clk);
        compare_model("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Basic image with a zero trailer must fail the checksum
        do_reset();
        load_basic();
        repeat (4) void'(stim.pop_back());
        push_word(32'd0);
        send(0);
        repeat (3) @(negedge clk);
        check("chk_bad_err", err, 1'b1);
        check("chk_bad_core_rst", core_rst, 1'b1);
        check("chk_bad_done", done, 1'b0);
`endif

        // Table of load scenarios
        foreach (vecs[v]) begin
            do_reset();
            build(vecs[v].n, 1'b0);
            send(vecs[v].gap);
            repeat (3) @(negedge clk);
            check($sformatf("tbl%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("tbl%0d_err", v), err, vecs[v].exp_err);
            compare_model($sformatf("tbl%0d", v));
        end

        // Random images
        for (int r = 0; r < 8; r++) begin
            do_reset();
            build(32'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0));
            send($urandom_range(0, 60));
            repeat (3) @(negedge clk);
            compare_model($sformatf("rnd%0d", r));
        end

        check("strobe_single_cycle", dbl_strobe, 0);
        check("done_err_exclusive", both_flags, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
